turn_scheduler: RTL and testbench
=================================

// Module: turn_scheduler
// PURPOSE
//  Game sequencer for the 3x3 tic-tac-toe datapath. Grants the board to P1, P2 or the random-move
//  generator one turn at a time. Times each human turn and substitutes a random move on timeout.
//  After every move it triggers the winner check and decides whether the game continues.
//  It sits between the top-level buttons/switches and the movement, board, winner-check modules.
// PARAMETERS
//  TIMEOUT_CYC  1000  clk cycles a human player has per turn before a random move is forced
//  CNT_W        10    turn-timer width; must satisfy 2**CNT_W >= TIMEOUT_CYC
// PORTS
//  clk            in   1      system clock
//  rst            in   1      reset, synchronous, active-low
//  start          in   1      start/restart request (level, sampled in IDLE/GAMEOVER only)
//  first_player   in   1      0: P1 moves first, 1: P2 moves first
//  two_player     in   1      1: P2 is human, 0: P2 is CPU (random move)
//  p1_done        in   1      P1 move committed (1-cycle pulse from movement block)
//  p2_done        in   1      P2 move committed (1-cycle pulse)
//  rand_done      in   1      random move committed (1-cycle pulse)
//  gameover       in   1      winner != 0, valid the cycle after en_check
//  board_full     in   1      all 9 cells occupied
//  en_p1          out  1      P1 owns the board
//  en_p2          out  1      P2 owns the board
//  en_rand        out  1      random generator owns the board
//  en_check       out  1      1-cycle strobe to the winner checker
//  timeout        out  1      1-cycle pulse when a human turn expires
//  current_player out  2      0 none, 1 P1, 2 P2
//  state          out  4      FSM state code, for debug LEDs
//  turn_count     out  4      moves committed this game, 0..9
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, all en_*/timeout=0, current_player=0, turn_count=0, timer=0.
//  At most one of en_p1/en_p2/en_rand is high in any cycle. All outputs are registered.
//  States/codes: IDLE 0, START 1, P1_TURN 2, P2_TURN 3, RAND_MOVE 4, CHECK 5, EVAL 6, SWITCH 7, GAMEOVER 8.
//  IDLE: outputs idle; start=1 -> START.
//  START (1 cyc): current_player = first_player ? 2 : 1; turn_count=0; timer=0.
//   Next state is P1_TURN or P2_TURN to match current_player.
//  P1_TURN: en_p1=1; timer+1 each cycle.
//   p1_done -> CHECK.
//   Else if timer==TIMEOUT_CYC-1: timeout pulse in the same cycle -> RAND_MOVE.
//  P2_TURN, two_player=1: same as P1_TURN, using en_p2 and p2_done.
//  P2_TURN, two_player=0: 1 cycle with no enable and no timeout pulse -> RAND_MOVE.
//  RAND_MOVE: en_rand=1 until rand_done -> CHECK. No timer here; never entered with a full board.
//  CHECK (1 cyc): en_check=1; turn_count+1, saturating at 9.
//  EVAL (1 cyc): gameover or board_full -> GAMEOVER (draw when gameover=0); otherwise -> SWITCH.
//  SWITCH (1 cyc): current_player toggles 1<->2; timer=0; next state is P1_TURN or P2_TURN.
//  GAMEOVER: enables 0; current_player and turn_count hold the last mover and count.
//   start=1 -> START. Board clearing is external.
//  Simultaneous done and timer expiry: done wins, no timeout pulse.
//  *_done while not owning the board is ignored. start outside IDLE/GAMEOVER is ignored.
//  rst=0 mid-game forces reset values at the next edge, whatever the state.
//  Timer width: compare at TIMEOUT_CYC-1; timer never wraps.
// TESTING
//  1. Reset, start with first_player=0, two_player=1 -> state 0->1->2, current_player=1, en_p1=1.
//  2. P1 pulses p1_done on cycle 5 -> en_check 1 cyc, turn_count=1, EVAL, SWITCH, en_p2=1, current_player=2.
//  3. P1 idle 1000 cyc -> timeout pulses exactly on cyc 1000 with en_rand=1 next;
//     rand_done -> CHECK.
//  4. two_player=0 -> after P1 move, P2_TURN lasts 1 cyc, then en_rand, no timeout pulse.
//  5. gameover=1 in EVAL -> GAMEOVER, current_player held; 9 moves with no winner -> GAMEOVER, turn_count=9.
//  6. p1_done coinciding with timer expiry -> no timeout, CHECK; rst=0 in RAND_MOVE -> IDLE, outputs 0.

Source files
------------

// File: rtl/turn_scheduler.sv
// turn_scheduler: tic-tac-toe game sequencer that grants the board to P1, P2 or the
// random-move generator, times human turns and drives the winner-check handshake.
module turn_scheduler #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_first_player,
  input  logic       i_two_player,
  input  logic       i_p1_done,
  input  logic       i_p2_done,
  input  logic       i_rand_done,
  input  logic       i_gameover,
  input  logic       i_board_full,
  output logic       o_en_p1,
  output logic       o_en_p2,
  output logic       o_en_rand,
  output logic       o_en_check,
  output logic       o_timeout,
  output logic [1:0] o_current_player,
  output logic [3:0] o_state,
  output logic [3:0] o_turn_count
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, START = 4'd1, P1_TURN = 4'd2, P2_TURN = 4'd3, RAND_MOVE = 4'd4,
    CHECK = 4'd5, EVAL = 4'd6, SWITCH = 4'd7, GAMEOVER = 4'd8
  } state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_timer;
  logic [1:0]       r_cp;
  logic [3:0]       r_tc;
  logic             r_en_p1, r_en_p2, r_en_rand, r_en_check, r_timeout;
  logic             w_to;
  always_ff @(posedge i_clk)
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_to   = 1'b0;
    case (r_state)
      IDLE:      w_next = i_start ? START : IDLE;
      START:     w_next = (r_cp == 2'd2) ? P2_TURN : P1_TURN;
      P1_TURN:
        if (i_p1_done) w_next = CHECK;
        else if (r_timer == LAST) begin
          w_to   = 1'b1;
          w_next = RAND_MOVE;
        end
      P2_TURN:
        if (!i_two_player) w_next = RAND_MOVE;
        else if (i_p2_done) w_next = CHECK;
        else if (r_timer == LAST) begin
          w_to   = 1'b1;
          w_next = RAND_MOVE;
        end
      RAND_MOVE: w_next = i_rand_done ? CHECK : RAND_MOVE;
      CHECK:     w_next = EVAL;
      EVAL:      w_next = (i_gameover || i_board_full) ? GAMEOVER : SWITCH;
      SWITCH:    w_next = (r_cp == 2'd2) ? P2_TURN : P1_TURN;
      GAMEOVER:  w_next = i_start ? START : GAMEOVER;
      default:   w_next = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge i_clk)
    if (!i_rst) begin
      r_timer    <= '0;
      r_cp       <= 2'd0;
      r_tc       <= 4'd0;
      r_en_p1    <= 1'b0;
      r_en_p2    <= 1'b0;
      r_en_rand  <= 1'b0;
      r_en_check <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_en_p1    <= w_next == P1_TURN;
      r_en_p2    <= w_next == P2_TURN && i_two_player;
      r_en_rand  <= w_next == RAND_MOVE;
      r_en_check <= w_next == CHECK;
      r_timeout  <= w_to;
      if (w_next == START || w_next == SWITCH) r_timer <= '0;
      else if ((r_state == P1_TURN || r_state == P2_TURN) && r_timer != '1) r_timer <= r_timer + 1'b1;
      if (w_next == START) r_cp <= i_first_player ? 2'd2 : 2'd1;
      else if (w_next == SWITCH) r_cp <= (r_cp == 2'd1) ? 2'd2 : 2'd1;
      if (w_next == START) r_tc <= 4'd0;
      else if (w_next == CHECK) r_tc <= (r_tc == 4'd9) ? 4'd9 : r_tc + 4'd1;
    end
  assign o_en_p1          = r_en_p1;
  assign o_en_p2          = r_en_p2;
  assign o_en_rand        = r_en_rand;
  assign o_en_check       = r_en_check;
  assign o_timeout        = r_timeout;
  assign o_current_player = r_cp;
  assign o_state          = r_state;
  assign o_turn_count     = r_tc;
endmodule

// File: tb/tb_turn_scheduler.sv
// tb_turn_scheduler: directed bench for turn_scheduler with hand-computed expectations.
module tb_turn_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, first_player = 1'b0, two_player = 1'b1;
  logic       p1_done = 1'b0, p2_done = 1'b0, rand_done = 1'b0;
  logic       gameover = 1'b0, board_full = 1'b0;
  logic       en_p1, en_p2, en_rand, en_check, timeout;
  logic [1:0] current_player;
  logic [3:0] state, turn_count;
  int         checks = 0, errors = 0;
  int         exp_cp;
  turn_scheduler dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_first_player(first_player),
    .i_two_player(two_player), .i_p1_done(p1_done), .i_p2_done(p2_done),
    .i_rand_done(rand_done), .i_gameover(gameover), .i_board_full(board_full),
    .o_en_p1(en_p1), .o_en_p2(en_p2), .o_en_rand(en_rand), .o_en_check(en_check),
    .o_timeout(timeout), .o_current_player(current_player), .o_state(state),
    .o_turn_count(turn_count)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    tick; tick;
    chk("rst_state", state, 0);
    chk("rst_en", {en_p1, en_p2, en_rand, en_check, timeout}, 0);
    chk("rst_cp", current_player, 0);
    chk("rst_tc", turn_count, 0);
    rst = 1'b1;
    tick;
    chk("idle_hold", state, 0);
    start = 1'b1;
    tick;
    chk("start_state", state, 1);
    chk("start_cp", current_player, 1);
    start = 1'b0;
    tick;
    chk("p1_state", state, 2);
    chk("p1_en", {en_p1, en_p2, en_rand}, 3'b100);
    tick; tick; tick; tick;
    p1_done = 1'b1;
    tick;
    p1_done = 1'b0;
    chk("chk_state", state, 5);
    chk("chk_en", {en_check, en_p1}, 2'b10);
    chk("chk_tc", turn_count, 1);
    tick;
    chk("eval_state", state, 6);
    chk("eval_strobe", en_check, 0);
    tick;
    chk("switch_state", state, 7);
    chk("switch_cp", current_player, 2);
    tick;
    chk("p2_state", state, 3);
    chk("p2_en", {en_p1, en_p2, en_rand}, 3'b010);
    p1_done = 1'b1; start = 1'b1;
    tick;
    p1_done = 1'b0; start = 1'b0;
    chk("ignore_state", state, 3);
    p2_done = 1'b1;
    tick;
    p2_done = 1'b0;
    chk("p2_chk_tc", turn_count, 2);
    tick; tick; tick;
    chk("p1_again", state, 2);
    chk("p1_again_cp", current_player, 1);
    repeat (999) tick;
    chk("pre_to_state", state, 2);
    chk("pre_to_pulse", timeout, 0);
    tick;
    chk("to_pulse", timeout, 1);
    chk("to_state", state, 4);
    chk("to_en", {en_p1, en_p2, en_rand}, 3'b001);
    tick;
    chk("to_one_cycle", timeout, 0);
    chk("rand_hold", en_rand, 1);
    rand_done = 1'b1;
    tick;
    rand_done = 1'b0;
    chk("rand_chk_state", state, 5);
    chk("rand_chk_tc", turn_count, 3);
    two_player = 1'b0;
    tick; tick; tick;
    chk("cpu_p2_state", state, 3);
    chk("cpu_p2_en", {en_p1, en_p2, en_rand}, 3'b000);
    tick;
    chk("cpu_rand_state", state, 4);
    chk("cpu_rand_en", {en_rand, timeout}, 2'b10);
    rand_done = 1'b1;
    tick;
    rand_done = 1'b0;
    chk("cpu_chk_tc", turn_count, 4);
    tick;
    gameover = 1'b1;
    tick;
    gameover = 1'b0;
    chk("win_state", state, 8);
    chk("win_cp", current_player, 2);
    chk("win_tc", turn_count, 4);
    chk("win_en", {en_p1, en_p2, en_rand, en_check}, 0);
    tick;
    chk("win_hold", state, 8);
    start = 1'b1; first_player = 1'b1; two_player = 1'b1;
    tick;
    start = 1'b0;
    chk("restart_cp", current_player, 2);
    chk("restart_tc", turn_count, 0);
    tick;
    chk("restart_p2", state, 3);
    exp_cp = 2;
    for (int i = 0; i < 9; i++) begin
      if (exp_cp == 2) p2_done = 1'b1;
      else p1_done = 1'b1;
      tick;
      p1_done = 1'b0; p2_done = 1'b0;
      chk("draw_chk_tc", turn_count, i + 1);
      tick;
      board_full = (i == 8);
      tick;
      if (i < 8) begin
        exp_cp = 3 - exp_cp;
        chk("draw_switch_cp", current_player, exp_cp);
        tick;
        chk("draw_turn_state", state, (exp_cp == 2) ? 3 : 2);
      end else begin
        chk("draw_state", state, 8);
        chk("draw_tc", turn_count, 9);
        chk("draw_cp", current_player, exp_cp);
      end
    end
    board_full = 1'b0;
    start = 1'b1; first_player = 1'b0;
    tick;
    start = 1'b0;
    tick;
    chk("race_p1", state, 2);
    repeat (999) tick;
    p1_done = 1'b1;
    tick;
    p1_done = 1'b0;
    chk("race_state", state, 5);
    chk("race_no_to", timeout, 0);
    two_player = 1'b0;
    tick; tick; tick;
    chk("race_p2", state, 3);
    tick;
    chk("mid_rand", state, 4);
    rst = 1'b0;
    tick;
    chk("midrst_state", state, 0);
    chk("midrst_en", {en_p1, en_p2, en_rand, en_check, timeout}, 0);
    chk("midrst_cp", current_player, 0);
    chk("midrst_tc", turn_count, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
